fifo_wr_ctrl: RTL and testbench

- Write-side controller of the UART system's async FIFO. Runs entirely in the write clock domain.
- Owns the write pointer and brings the read-domain Gray pointer into the write domain.
- Produces the memory write address, FULL, ALMOST_FULL and a sticky OVERFLOW flag.
- Feeds the FIFO memory (wr_addr, FULL) and exports its Gray pointer to the read-side controller.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_wr_ctrl_if.sv | 22 ++
 rtl/sync_ptr.sv | 34 +++
 rtl/fifo_wr_ctrl.sv | 77 +++++++
 tb/tb_fifo_wr_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the write- and read-side controllers of the async FIFO.
// Functions work on 32-bit values; callers cast in and out at their own pointer width.
package fifo_pkg;

    localparam int unsigned MaxPtrWd = 31;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // XOR prefix from the MSB down; zero upper bits leave narrower pointers intact.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

    function automatic bit ptr_cfg_ok(input int unsigned ptr_wd, input int unsigned depth);
        return (ptr_wd >= 3) && (ptr_wd <= MaxPtrWd) && (depth == (32'd1 << (ptr_wd - 1)));
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side FIFO controller bus: request and foreign read pointer in, address and flags out.
interface fifo_wr_ctrl_if #(
    parameter int unsigned PTR_WD = 4
);
    logic              W_INC;
    logic [PTR_WD-1:0] RD_PTR_GRAY;
    logic [PTR_WD-2:0] WR_ADDR;
    logic [PTR_WD-1:0] WR_PTR_GRAY;
    logic              FULL;
    logic              ALMOST_FULL;
    logic              OVERFLOW;

    modport master (
        output W_INC, RD_PTR_GRAY,
        input  WR_ADDR, WR_PTR_GRAY, FULL, ALMOST_FULL, OVERFLOW
    );

    modport slave (
        input  W_INC, RD_PTR_GRAY,
        output WR_ADDR, WR_PTR_GRAY, FULL, ALMOST_FULL, OVERFLOW
    );
endinterface

// File: rtl/sync_ptr.sv
// Multi-stage flop chain carrying a Gray pointer across clock domains.
module sync_ptr #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: write pointer, read-pointer sync, FULL/ALMOST_FULL/OVERFLOW.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned PTR_WD      = 4,
    parameter int unsigned FIFO_DP     = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_LEVEL    = 6
) (
    input  logic          W_CLK,
    input  logic          W_RST,
    fifo_wr_ctrl_if.slave bus
);
    typedef logic [PTR_WD-1:0] ptr_t;

    if (!ptr_cfg_ok(PTR_WD, FIFO_DP)) begin : g_bad_depth
        $error("FIFO_DP must equal 2**(PTR_WD-1) with PTR_WD >= 3");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DP) begin : g_bad_af
        $error("AF_LEVEL must lie in 1..FIFO_DP");
    end

    ptr_t bin_q, bin_d;
    ptr_t gray_q, gray_d;
    logic full_q, full_d;
    logic af_q, af_d;
    logic ovf_q, ovf_d;
    ptr_t rq, rbin, level;
    logic wr_en;

    sync_ptr #(
        .WIDTH  (PTR_WD),
        .STAGES (SYNC_STAGES)
    ) u_sync_rd (
        .clk_i (W_CLK),
        .rst_i (W_RST),
        .d_i   (bus.RD_PTR_GRAY),
        .q_o   (rq)
    );

    always_comb begin
        wr_en  = bus.W_INC & ~full_q;
        bin_d  = wr_en ? bin_q + ptr_t'(1) : bin_q;
        gray_d = ptr_t'(bin2gray(32'(bin_d)));
        rbin   = ptr_t'(gray2bin(32'(rq)));
        level  = bin_d - rbin;
        // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
        full_d = (gray_d == {~rq[PTR_WD-1 -: 2], rq[PTR_WD-3:0]});
        af_d   = 32'(level) >= AF_LEVEL;
        ovf_d  = ovf_q | (bus.W_INC & full_q);
    end

    always_ff @(posedge W_CLK or posedge W_RST) begin
        if (W_RST) begin
            bin_q  <= '0;
            gray_q <= '0;
            full_q <= 1'b0;
            af_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            full_q <= full_d;
            af_q   <= af_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.WR_ADDR     = bin_q[PTR_WD-2:0];
    assign bus.WR_PTR_GRAY = gray_q;
    assign bus.FULL        = full_q;
    assign bus.ALMOST_FULL = af_q;
    assign bus.OVERFLOW    = ovf_q;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed self-checking bench for fifo_wr_ctrl (PTR_WD=4, depth 8, 2 sync stages, AF at 6).
module tb_fifo_wr_ctrl;
    logic W_CLK = 1'b0;
    logic W_RST = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    fifo_wr_ctrl_if #(.PTR_WD(4)) bus ();

    fifo_wr_ctrl #(
        .PTR_WD      (4),
        .FIFO_DP     (8),
        .SYNC_STAGES (2),
        .AF_LEVEL    (6)
    ) dut (
        .W_CLK (W_CLK),
        .W_RST (W_RST),
        .bus   (bus)
    );

    always #5 W_CLK = ~W_CLK;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge W_CLK);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_addr"}, 32'(bus.WR_ADDR), 0);
        check_eq({tag, "_gray"}, 32'(bus.WR_PTR_GRAY), 0);
        check_eq({tag, "_full"}, 32'(bus.FULL), 0);
        check_eq({tag, "_af"}, 32'(bus.ALMOST_FULL), 0);
        check_eq({tag, "_ovf"}, 32'(bus.OVERFLOW), 0);
    endtask

    // Pulse reset between edges, hold across one edge, release mid-cycle.
    task automatic do_reset(input string tag);
        W_RST = 1'b1;
        #1;
        check_cleared(tag);
        bus.W_INC       = 1'b0;
        bus.RD_PTR_GRAY = '0;
        step();
        W_RST = 1'b0;
    endtask

    logic [3:0] fill_gray [8];
    logic [3:0] prev_gray;

    initial begin
        fill_gray = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
        bus.W_INC       = 1'b0;
        bus.RD_PTR_GRAY = '0;
        #2;
        do_reset("rst_init");

        // Fill eight entries against a read pointer parked at 0.
        bus.W_INC = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq($sformatf("fill_gray%0d", k), 32'(bus.WR_PTR_GRAY), 32'(fill_gray[k-1]));
            check_eq($sformatf("fill_addr%0d", k), 32'(bus.WR_ADDR), 32'(k % 8));
            check_eq($sformatf("fill_af%0d", k), 32'(bus.ALMOST_FULL), 32'(k >= 6));
            check_eq($sformatf("fill_full%0d", k), 32'(bus.FULL), 32'(k == 8));
        end

        // One rejected write while full.
        step();
        bus.W_INC = 1'b0;
        check_eq("ovf_gray", 32'(bus.WR_PTR_GRAY), 32'hC);
        check_eq("ovf_addr", 32'(bus.WR_ADDR), 0);
        check_eq("ovf_set", 32'(bus.OVERFLOW), 1);
        check_eq("ovf_full", 32'(bus.FULL), 1);
        step();
        step();
        check_eq("ovf_sticky", 32'(bus.OVERFLOW), 1);

        // Drain one entry: FULL drops on the third edge.
        bus.RD_PTR_GRAY = 4'h1;
        step();
        check_eq("drain_full_e1", 32'(bus.FULL), 1);
        step();
        check_eq("drain_full_e2", 32'(bus.FULL), 1);
        step();
        check_eq("drain_full_e3", 32'(bus.FULL), 0);
        check_eq("drain_af", 32'(bus.ALMOST_FULL), 1);
        bus.W_INC = 1'b1;
        step();
        bus.W_INC = 1'b0;
        check_eq("refill_full", 32'(bus.FULL), 1);
        check_eq("refill_gray", 32'(bus.WR_PTR_GRAY), 32'hD);
        check_eq("refill_addr", 32'(bus.WR_ADDR), 1);
        check_eq("refill_ovf", 32'(bus.OVERFLOW), 1);
        do_reset("rst_ovf");

        // Write accepted at level 7 while the read pointer moves on the same edge.
        bus.W_INC = 1'b1;
        repeat (7) step();
        check_eq("sim_pre_full", 32'(bus.FULL), 0);
        check_eq("sim_pre_af", 32'(bus.ALMOST_FULL), 1);
        step();
        bus.W_INC       = 1'b0;
        bus.RD_PTR_GRAY = 4'h1;
        check_eq("sim_gray", 32'(bus.WR_PTR_GRAY), 32'hC);
        check_eq("sim_full_a", 32'(bus.FULL), 1);
        step();
        check_eq("sim_full_b", 32'(bus.FULL), 1);
        step();
        check_eq("sim_full_c", 32'(bus.FULL), 1);
        step();
        check_eq("sim_full_d", 32'(bus.FULL), 0);
        check_eq("sim_ovf", 32'(bus.OVERFLOW), 0);
        do_reset("rst_sim");

        // Twenty writes with the reader trailing by two; pointer wraps 15 -> 0.
        prev_gray = '0;
        bus.W_INC = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            check_eq($sformatf("wrap_gray%0d", e), 32'(bus.WR_PTR_GRAY),
                     32'(to_gray(4'(e))));
            check_eq($sformatf("wrap_1bit%0d", e), $countones(bus.WR_PTR_GRAY ^ prev_gray), 1);
            check_eq($sformatf("wrap_addr%0d", e), 32'(bus.WR_ADDR), 32'(e % 8));
            check_eq($sformatf("wrap_full%0d", e), 32'(bus.FULL), 0);
            check_eq($sformatf("wrap_af%0d", e), 32'(bus.ALMOST_FULL), 0);
            prev_gray       = bus.WR_PTR_GRAY;
            bus.RD_PTR_GRAY = (e >= 2) ? to_gray(4'(e - 2)) : 4'h0;
        end
        bus.W_INC = 1'b0;
        do_reset("rst_wrap");

        // Reset asserted mid-stream after five writes, then restart from empty.
        bus.W_INC = 1'b1;
        repeat (5) step();
        check_eq("mid_addr_pre", 32'(bus.WR_ADDR), 5);
        W_RST = 1'b1;
        #1;
        check_cleared("rst_mid");
        step();
        W_RST = 1'b0;
        step();
        bus.W_INC = 1'b0;
        check_eq("post_rst_gray", 32'(bus.WR_PTR_GRAY), 1);
        check_eq("post_rst_addr", 32'(bus.WR_ADDR), 1);
        check_eq("post_rst_full", 32'(bus.FULL), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
